// File: rtl/pmux_prog_ctrl_if.sv
// Byte stream between the configuration source and the pmux programming controller:
// configuration bytes flowing in and readback bytes flowing back out.
interface pmux_prog_ctrl_if;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] rb_data;
    logic       rb_valid;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready,
        input  rb_data,
        input  rb_valid
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready,
        output rb_data,
        output rb_valid
    );
endinterface

// File: rtl/pmux_prog_ctrl.sv
// Serialises configuration bytes into a pmux4 chain using two non-overlapping
// programming clocks, and captures the bits shifted out of the chain as readback.
module pmux_prog_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    pmux_prog_ctrl_if.slave cfg,
    output logic            chain_in,
    input  logic            chain_out,
    output logic            prog_clk0,
    output logic            prog_clk1
);
    localparam int NWORDS   = (CHAIN_LEN + 7) / 8;
    localparam int WW       = $clog2(NWORDS + 1);
    localparam int LAST_BIT = (CHAIN_LEN % 8 == 0) ? 7 : (CHAIN_LEN % 8) - 1;
    localparam int CMAX     = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW       = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, PH0, GAP0, PH1, GAP1, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cyc_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [WW-1:0] word_cnt_reg;
    logic [6:0]    shift_reg;
    logic [7:0]    rb_shift_reg;
    logic [7:0]    rb_data_reg;
    logic          rb_valid_reg;
    logic          chain_in_reg;
    logic          clk0_reg;
    logic          clk1_reg;

    logic pulse_end, gap_end, last_bit, last_slot;
    logic load_byte, next_bit, exit_byte;

    assign pulse_end = (cyc_cnt_reg == CW'(PULSE_CYC - 1));
    assign gap_end   = (cyc_cnt_reg == CW'(GAP_CYC - 1));
    assign last_bit  = (bit_idx_reg == 3'd7);
    // word_cnt_reg holds the 1-based number of the byte currently being shifted
    assign last_slot = (word_cnt_reg == WW'(NWORDS)) && (bit_idx_reg == 3'(LAST_BIT));

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_next = LOAD;
                LOAD:    if (cfg.cfg_valid) state_next = SETUP;
                SETUP:   state_next = PH0;
                PH0:     if (pulse_end) state_next = GAP0;
                GAP0:    if (gap_end) state_next = PH1;
                PH1:     if (pulse_end) state_next = GAP1;
                GAP1: begin
                    if (gap_end) begin
                        if (last_slot)     state_next = DONE;
                        else if (last_bit) state_next = LOAD;
                        else               state_next = SETUP;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign load_byte = (state_reg == LOAD) && (state_next == SETUP);
    assign next_bit  = (state_reg == GAP1) && (state_next == SETUP);
    assign exit_byte = (state_reg == GAP1) && ((state_next == LOAD) || (state_next == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cyc_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            word_cnt_reg <= '0;
            shift_reg    <= '0;
            rb_data_reg  <= '0;
            rb_valid_reg <= 1'b0;
            chain_in_reg <= 1'b0;
            clk0_reg     <= 1'b0;
            clk1_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            // Programming clocks come straight from these flops, decoded from the next state
            clk0_reg     <= (state_next == PH0);
            clk1_reg     <= (state_next == PH1);
            rb_valid_reg <= exit_byte;
            if (state_next != state_reg) cyc_cnt_reg <= '0;
            else                         cyc_cnt_reg <= cyc_cnt_reg + 1'b1;

            if (state_reg == IDLE) begin
                bit_idx_reg  <= '0;
                word_cnt_reg <= '0;
            end
            // chain_in only moves on entry to SETUP, after a full clock-low gap
            if (load_byte) begin
                shift_reg    <= cfg.cfg_data[7:1];
                chain_in_reg <= cfg.cfg_data[0];
                bit_idx_reg  <= '0;
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
            if (next_bit) begin
                shift_reg    <= {1'b0, shift_reg[6:1]};
                chain_in_reg <= shift_reg[0];
                bit_idx_reg  <= bit_idx_reg + 1'b1;
            end
            if (exit_byte) rb_data_reg <= rb_shift_reg;
            if (abort && (state_reg != IDLE)) chain_in_reg <= 1'b0;
        end
    end

    // Readback bits are cleared per byte so a partial final byte reads 0 above its used bits
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rb
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    rb_shift_reg[gi] <= 1'b0;
                else if (load_byte)
                    rb_shift_reg[gi] <= 1'b0;
                else if ((state_reg == SETUP) && (bit_idx_reg == 3'(gi)))
                    rb_shift_reg[gi] <= chain_out;
            end
        end
    endgenerate

    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign cfg.cfg_ready = (state_reg == LOAD);
    assign cfg.rb_data   = rb_data_reg;
    assign cfg.rb_valid  = rb_valid_reg;
    assign chain_in      = chain_in_reg;
    assign prog_clk0     = clk0_reg;
    assign prog_clk1     = clk1_reg;
endmodule

// File: tb/tb_pmux_prog_ctrl.sv
// Scoreboard bench for pmux_prog_ctrl: a default 16-slot instance and a 10-slot instance
// with wider pulses, each driving a two-phase shift-chain model.
module tb_pmux_prog_ctrl;
    localparam int PB = 3;
    localparam int GB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pmux_prog_ctrl_if if_a();
    pmux_prog_ctrl_if if_b();

    logic start_a = 1'b0, abort_a = 1'b0, busy_a, done_a, ci_a, co_a, c0_a, c1_a;
    logic start_b = 1'b0, abort_b = 1'b0, busy_b, done_b, ci_b, co_b, c0_b, c1_b;

    pmux_prog_ctrl u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
        .cfg(if_a), .chain_in(ci_a), .chain_out(co_a), .prog_clk0(c0_a), .prog_clk1(c1_a)
    );

    pmux_prog_ctrl #(.CHAIN_LEN(10), .PULSE_CYC(PB), .GAP_CYC(GB)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
        .cfg(if_b), .chain_in(ci_b), .chain_out(co_b), .prog_clk0(c0_b), .prog_clk1(c1_b)
    );

    // Two-phase chain models: master latches on prog_clk0, slave on prog_clk1
    logic [15:0] mm_a, ms_a, pre_a;
    logic        ld_a = 1'b0;
    always @(posedge c0_a) mm_a <= {ms_a[14:0], ci_a};
    always @(posedge c1_a or posedge ld_a) if (ld_a) ms_a <= pre_a; else ms_a <= mm_a;
    assign co_a = ms_a[15];

    logic [9:0] mm_b, ms_b, pre_b;
    logic       ld_b = 1'b0;
    always @(posedge c0_b) mm_b <= {ms_b[8:0], ci_b};
    always @(posedge c1_b or posedge ld_b) if (ld_b) ms_b <= pre_b; else ms_b <= mm_b;
    assign co_b = ms_b[9];

    int n_checks = 0;
    int n_fail   = 0;

    logic       chq_a[$], chq_b[$];
    logic [7:0] rbq_a[$], rbq_b[$];
    int         doneq_a[$], doneq_b[$];
    bit         chk_a = 1'b0, chk_b = 1'b0;
    int         t0_a = 0, t0_b = 0;

    int   n0_a = 0, n1_a = 0, w0_a = 0, w1_a = 0, low_a = 0, ndone_a = 0;
    int   n0_b = 0, n1_b = 0, w0_b = 0, w1_b = 0, low_b = 0, ndone_b = 0;
    logic pc0_a = 1'b0, pc1_a = 1'b0, pci_a = 1'b0;
    logic pc0_b = 1'b0, pc1_b = 1'b0, pci_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred or bound expired, required none", name);
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[15-i];
        return r;
    endfunction

    function automatic logic [9:0] rev10(input logic [9:0] x);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = x[9-i];
        return r;
    endfunction

    // Monitor for instance A
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("no_overlap_a", 32'(c0_a & c1_a), 32'd0);
                if (if_a.cfg_ready) check("stall_clocks_low_a", {30'd0, c0_a, c1_a}, 32'd0);
                if ((ci_a !== pci_a) && busy_a) check("chain_in_stable_a", 32'(low_a >= 1), 32'd1);
                if (c0_a && !pc0_a) begin
                    n0_a++;
                    if (chk_a) begin
                        if (chq_a.size() == 0) fail_now("chain_in_a_extra_slot");
                        else check("chain_in_a", 32'(ci_a), 32'(chq_a.pop_front()));
                    end
                end
                if (c1_a && !pc1_a) n1_a++;
                if (pc0_a && !c0_a) begin
                    if (chk_a) check("pulse0_width_a", w0_a, 32'd2);
                    w0_a = 0;
                end
                if (pc1_a && !c1_a) begin
                    if (chk_a) check("pulse1_width_a", w1_a, 32'd2);
                    w1_a = 0;
                end
                if (c0_a) w0_a++;
                if (c1_a) w1_a++;
                low_a = (c0_a | c1_a) ? 0 : low_a + 1;
                if (done_a) begin
                    ndone_a++;
                    if (doneq_a.size() == 0) fail_now("done_a_unexpected");
                    else check("done_latency_a", cyc - t0_a, doneq_a.pop_front());
                end
                if (if_a.rb_valid) begin
                    if (rbq_a.size() == 0) fail_now("rb_valid_a_unexpected");
                    else check("rb_data_a", 32'(if_a.rb_data), 32'(rbq_a.pop_front()));
                end
                pc0_a = c0_a;
                pc1_a = c1_a;
                pci_a = ci_a;
            end
        end
    end

    // Monitor for instance B
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("no_overlap_b", 32'(c0_b & c1_b), 32'd0);
                if (if_b.cfg_ready) check("stall_clocks_low_b", {30'd0, c0_b, c1_b}, 32'd0);
                if ((ci_b !== pci_b) && busy_b) check("chain_in_stable_b", 32'(low_b >= GB), 32'd1);
                if (c0_b && !pc0_b) begin
                    n0_b++;
                    if (chk_b) begin
                        if (chq_b.size() == 0) fail_now("chain_in_b_extra_slot");
                        else check("chain_in_b", 32'(ci_b), 32'(chq_b.pop_front()));
                    end
                end
                if (c1_b && !pc1_b) n1_b++;
                if (pc0_b && !c0_b) begin
                    if (chk_b) check("pulse0_width_b", w0_b, PB);
                    w0_b = 0;
                end
                if (pc1_b && !c1_b) begin
                    if (chk_b) check("pulse1_width_b", w1_b, PB);
                    w1_b = 0;
                end
                if (c0_b) w0_b++;
                if (c1_b) w1_b++;
                low_b = (c0_b | c1_b) ? 0 : low_b + 1;
                if (done_b) begin
                    ndone_b++;
                    if (doneq_b.size() == 0) fail_now("done_b_unexpected");
                    else check("done_latency_b", cyc - t0_b, doneq_b.pop_front());
                end
                if (if_b.rb_valid) begin
                    if (rbq_b.size() == 0) fail_now("rb_valid_b_unexpected");
                    else check("rb_data_b", 32'(if_b.rb_data), 32'(rbq_b.pop_front()));
                end
                pc0_b = c0_b;
                pc1_b = c1_b;
                pci_b = ci_b;
            end
        end
    end

    // One full 16-slot pass on A; optional second start issued mid-pass
    task automatic run_a(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] r0, input logic [7:0] r1, input bit extra);
        logic [15:0] seq;
        int s0, s1, sd, n;
        seq = {b1, b0};
        for (int i = 0; i < 16; i++) chq_a.push_back(seq[i]);
        rbq_a.push_back(r0);
        rbq_a.push_back(r1);
        doneq_a.push_back(115);
        chk_a = 1'b1;
        s0 = n0_a; s1 = n1_a; sd = ndone_a;
        @(negedge clk);
        if_a.cfg_data = b0; if_a.cfg_valid = 1'b1; start_a = 1'b1; t0_a = cyc;
        @(negedge clk);
        start_a = 1'b0;
        check("busy_after_start_a", 32'(busy_a), 32'd1);
        check("ready_after_start_a", 32'(if_a.cfg_ready), 32'd1);
        @(posedge clk); #1;
        if_a.cfg_data = b1;
        if (extra) begin
            repeat (30) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        n = 0;
        while (!if_a.cfg_ready && n < 200) begin @(negedge clk); n++; end
        if (!if_a.cfg_ready) fail_now("timeout_ready_a");
        @(posedge clk); #1;
        if_a.cfg_valid = 1'b0;
        n = 0;
        while (!done_a && n < 300) begin @(negedge clk); n++; end
        if (!done_a) fail_now("timeout_done_a");
        repeat (extra ? 150 : 5) @(negedge clk);
        check("prog_clk0_pulses_a", n0_a - s0, 32'd16);
        check("prog_clk1_pulses_a", n1_a - s1, 32'd16);
        check("done_count_a", ndone_a - sd, 32'd1);
        check("chain_model_a", 32'(rev16(ms_a)), 32'(seq));
        check("chain_queue_left_a", chq_a.size(), 32'd0);
        check("rb_queue_left_a", rbq_a.size(), 32'd0);
    endtask

    initial begin
        int n, s0, s1;
        logic [9:0] seq_b;
        if_a.cfg_data = 8'h00; if_a.cfg_valid = 1'b0;
        if_b.cfg_data = 8'h00; if_b.cfg_valid = 1'b0;
        #2;
        pre_a = rev16(16'hC35A); pre_b = rev10(10'h2B7);
        ld_a = 1'b1; ld_b = 1'b1;
        #1;
        ld_a = 1'b0; ld_b = 1'b0;
        #9;
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_ready_a", 32'(if_a.cfg_ready), 32'd0);
        check("rst_rb_data_a", 32'(if_a.rb_data), 32'd0);
        check("rst_rb_valid_a", 32'(if_a.rb_valid), 32'd0);
        check("rst_outs_a", {29'd0, ci_a, c0_a, c1_a}, 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_outs_b", {29'd0, ci_b, c0_b, c1_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full pass with readback of the preloaded chain, then a pass with a stray start
        run_a(8'hA5, 8'h3C, 8'h5A, 8'hC3, 1'b0);
        run_a(8'h0F, 8'hF0, 8'hA5, 8'h3C, 1'b1);

        // start and abort together while idle: abort wins
        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check("start_abort_idle_busy", 32'(busy_a), 32'd0);
        check("start_abort_idle_ready", 32'(if_a.cfg_ready), 32'd0);

        // Abort in the second cycle of a prog_clk1 pulse
        chk_a = 1'b0;
        @(negedge clk);
        if_a.cfg_data = 8'h55; if_a.cfg_valid = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0; s1 = 0;
        while (s1 < 2 && n < 100) begin
            @(negedge clk);
            n++;
            s1 = c1_a ? s1 + 1 : 0;
        end
        if (s1 < 2) fail_now("timeout_clk1_a");
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0; if_a.cfg_valid = 1'b0;
        check("abort_clocks", {30'd0, c0_a, c1_a}, 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_chain_in", 32'(ci_a), 32'd0);
        s0 = ndone_a;
        repeat (20) @(negedge clk);
        check("abort_no_done", ndone_a - s0, 32'd0);

        // Asynchronous reset while prog_clk0 is high
        @(negedge clk);
        if_a.cfg_data = 8'h81; if_a.cfg_valid = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!c0_a && n < 100) begin @(negedge clk); n++; end
        if (!c0_a) fail_now("timeout_clk0_a");
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_clocks", {30'd0, c0_a, c1_a}, 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_ready", 32'(if_a.cfg_ready), 32'd0);
        check("rst_mid_rb_data", 32'(if_a.rb_data), 32'd0);
        check("rst_mid_chain_in", 32'(ci_a), 32'd0);
        check("rst_mid_done_rbv", {30'd0, done_a, if_a.rb_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0; if_a.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Partial final byte with a 20-cycle stall before it on the 10-slot instance
        seq_b = 10'h396;
        for (int i = 0; i < 10; i++) chq_b.push_back(seq_b[i]);
        rbq_b.push_back(8'hB7);
        rbq_b.push_back(8'h02);
        doneq_b.push_back(133);
        chk_b = 1'b1;
        s0 = n0_b; s1 = n1_b;
        @(negedge clk);
        if_b.cfg_data = 8'h96; if_b.cfg_valid = 1'b1; start_b = 1'b1; t0_b = cyc;
        @(negedge clk);
        start_b = 1'b0;
        @(posedge clk); #1;
        if_b.cfg_valid = 1'b0; if_b.cfg_data = 8'hFF;
        n = 0;
        while (!if_b.cfg_ready && n < 200) begin @(negedge clk); n++; end
        if (!if_b.cfg_ready) fail_now("timeout_ready_b");
        repeat (20) @(negedge clk);
        if_b.cfg_valid = 1'b1;
        @(posedge clk); #1;
        if_b.cfg_valid = 1'b0;
        n = 0;
        while (!done_b && n < 400) begin @(negedge clk); n++; end
        if (!done_b) fail_now("timeout_done_b");
        repeat (5) @(negedge clk);
        check("prog_clk0_pulses_b", n0_b - s0, 32'd10);
        check("prog_clk1_pulses_b", n1_b - s1, 32'd10);
        check("done_count_b", ndone_b, 32'd1);
        check("chain_model_b", 32'(rev10(ms_b)), 32'h396);
        check("chain_queue_left_b", chq_b.size(), 32'd0);
        check("rb_queue_left_b", rbq_b.size(), 32'd0);
        check("done_queue_left", doneq_a.size() + doneq_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
